video_ram_scanner: RTL and testbench

- Read-side consumer of the 2048x9 video RAM; sits directly downstream of it, on the RAM's read clock.
- Generates LCD/VGA raster timing and a registered 11-bit read address.
- Compensates the RAM's pipelined read latency and serialises each 9-bit word into 8 monochrome pixels, time-aligned with hsync/vsync/de.
- Image window is 32 words x 8 px = 256 px wide by 64 lines, anchored top-left of the active area.

---
 rtl/video_ram_pkg.sv | 36 +++
 rtl/video_timing_gen.sv | 56 +++++
 rtl/video_ram_scanner.sv | 161 ++++++++++++++++
 tb/tb_video_ram_scanner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/video_ram_pkg.sv
// Shared types and constants for the video RAM read path.
package video_ram_pkg;

  localparam int unsigned WIN_WORDS    = 32;
  localparam int unsigned WIN_LINES    = 64;
  localparam int unsigned ADDR_W       = 11;
  localparam int unsigned DATA_W       = 9;
  localparam int unsigned PIX_PER_WORD = 8;
  localparam int unsigned WIN_PIXELS   = WIN_WORDS * PIX_PER_WORD;
  localparam int unsigned CNT_W        = 12;
  localparam int unsigned HSUB_W       = 3;

  // One RAM word: attribute in the MSB, pixels below with bit 7 leftmost.
  typedef struct packed {
    logic       attr;
    logic [7:0] pixels;
  } vram_word_t;

  // Per-pixel timing tag carried alongside the RAM read latency.
  typedef struct packed {
    logic              hsync;
    logic              vsync;
    logic              de;
    logic              in_win;
    logic              frame;
    logic [HSUB_W-1:0] hsub;
  } scan_tag_t;

  function automatic int unsigned raster_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with raw (undelayed) sync, enable and frame flags.
module video_timing_gen
  import video_ram_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 8,
  parameter int unsigned H_SYNC   = 4,
  parameter int unsigned H_BP     = 43,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             hsync_raw_c,
  output logic             vsync_raw_c,
  output logic             de_raw_c,
  output logic             frame_raw_c
);

  localparam int unsigned H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // v advances only on h wrap; both wrap together at the frame end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + CNT_W'(1);
    end else begin
      h <= h + CNT_W'(1);
    end
  end

  always_comb begin
    hsync_raw_c = (h >= HS_FIRST) && (h <= HS_LAST);
    vsync_raw_c = (v >= VS_FIRST) && (v <= VS_LAST);
    de_raw_c    = (h < H_ACT) && (v < V_ACT);
    frame_raw_c = (h == '0) && (v == '0);
  end

endmodule

// File: rtl/video_ram_scanner.sv
// Raster scanner reading the 2048x9 video RAM and serialising words to monochrome pixels.
// Optional blink attribute support is enabled by defining VIDEO_RAM_SCANNER_BLINK_EN.
module video_ram_scanner
  import video_ram_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 480,
  parameter int unsigned H_FP        = 8,
  parameter int unsigned H_SYNC      = 4,
  parameter int unsigned H_BP        = 43,
  parameter int unsigned V_ACTIVE    = 272,
  parameter int unsigned V_FP        = 4,
  parameter int unsigned V_SYNC      = 4,
  parameter int unsigned V_BP        = 12,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] read_ad,
  input  logic [DATA_W-1:0] read_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              pixel,
  output logic              frame_start
);

  // Address register plus RD_LAT RAM stages; the output register adds the last stage.
  localparam int unsigned TAG_DEPTH = RD_LAT + 1;

  localparam logic [CNT_W-1:0] WIN_H = CNT_W'(WIN_PIXELS);
  localparam logic [CNT_W-1:0] WIN_V = CNT_W'(WIN_LINES);

  localparam scan_tag_t TAG_IDLE = '{
    hsync:  ~SYNC_ACTIVE,
    vsync:  ~SYNC_ACTIVE,
    de:     1'b0,
    in_win: 1'b0,
    frame:  1'b0,
    hsub:   '0
  };

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             hsync_raw_c;
  logic             vsync_raw_c;
  logic             de_raw_c;
  logic             frame_raw_c;
  logic             in_win_c;
  scan_tag_t        tag_c;
  scan_tag_t        tag_q [TAG_DEPTH];
  scan_tag_t        tag_out_c;
  vram_word_t       word_c;
  logic             blank_c;
  logic             pixel_c;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset_n     (reset_n),
    .h           (h),
    .v           (v),
    .hsync_raw_c (hsync_raw_c),
    .vsync_raw_c (vsync_raw_c),
    .de_raw_c    (de_raw_c),
    .frame_raw_c (frame_raw_c)
  );

  always_comb begin
    in_win_c      = de_raw_c && (h < WIN_H) && (v < WIN_V);
    tag_c         = TAG_IDLE;
    tag_c.hsync   = hsync_raw_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    tag_c.vsync   = vsync_raw_c ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    tag_c.de      = de_raw_c;
    tag_c.in_win  = in_win_c;
    tag_c.frame   = frame_raw_c;
    tag_c.hsub    = h[HSUB_W-1:0];
  end

  // Address holds outside the window so the RAM output stays quiet during blanking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_ad <= '0;
    end else if (in_win_c) begin
      read_ad <= ADDR_W'({v[5:0], h[7:3]});
    end
  end

  // Tag delay line matching the address register plus RAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(TAG_DEPTH); i++) begin
        tag_q[i] <= TAG_IDLE;
      end
    end else begin
      tag_q[0] <= tag_c;
      for (int i = 1; i < int'(TAG_DEPTH); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

`ifdef VIDEO_RAM_SCANNER_BLINK_EN
  logic [5:0] frame_cnt;
  logic       blink_phase;

  // Phase is sampled before the increment so frames 0..31 show and 32..63 blank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_raw_c) begin
      frame_cnt   <= frame_cnt + 6'(1);
      blink_phase <= frame_cnt[5];
    end
  end

  always_comb begin
    blank_c = word_c.attr && blink_phase;
  end
`else
  logic unused_attr_c;

  always_comb begin
    unused_attr_c = word_c.attr;
    blank_c       = 1'b0;
  end
`endif

  always_comb begin
    tag_out_c = tag_q[TAG_DEPTH-1];
    word_c    = vram_word_t'(read_data);
    pixel_c   = tag_out_c.in_win && !blank_c &&
                word_c.pixels[HSUB_W'(3'd7 - tag_out_c.hsub)];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      de          <= 1'b0;
      pixel       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= tag_out_c.hsync;
      vsync       <= tag_out_c.vsync;
      de          <= tag_out_c.de;
      pixel       <= pixel_c;
      frame_start <= tag_out_c.frame;
    end
  end

endmodule

// File: tb/tb_video_ram_scanner.sv
// Directed bench for video_ram_scanner with a two-stage registered RAM model.
module tb_video_ram_scanner;

  logic        clk;
  logic        reset_n;
  logic [10:0] read_ad;
  logic [8:0]  read_data;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        pixel;
  logic        frame_start;

  logic [8:0]  mem [2048];
  logic [10:0] ram_a;
  logic [8:0]  ram_q;

  int n_cmp;
  int n_bad;
  int cyc;

  video_ram_scanner dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .read_ad     (read_ad),
    .read_data   (read_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .pixel       (pixel),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output-register read mode: address captured, then data registered.
  always @(posedge clk) begin
    ram_a <= read_ad;
    ram_q <= mem[ram_a];
  end
  assign read_data = ram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_pixel"}, 32'(pixel), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_read_ad"}, 32'(read_ad), 32'd0);
  endtask

  initial begin
    int c0;
    int fall1;
    logic [7:0] pat;
    int ks   [8];
    int exps [8];

    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 9'h000;
    mem[0] = 9'h0A5;

    // Power-on reset.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;

    // First frame_start and word 0 serialisation.
    while (frame_start !== 1'b1 && cyc < 20) step();
    chk("first_frame_start_edge", 32'(cyc), 32'd4);
    c0  = cyc;
    pat = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      chk("word0_de", 32'(de), 32'd1);
      chk("word0_pixel", 32'(pixel), 32'(pat[7-i]));
      if (i == 1) chk("frame_start_one_clk", 32'(frame_start), 32'd0);
      step();
    end

    // Horizontal timing relative to the rising de of the first line.
    while (hsync !== 1'b0 && cyc < c0 + 1000) step();
    chk("de_to_hsync_fall", 32'(cyc - c0), 32'd488);
    chk("de_low_in_hsync", 32'(de), 32'd0);
    fall1 = cyc;
    while (hsync === 1'b0 && cyc < fall1 + 100) step();
    chk("hsync_width", 32'(cyc - fall1), 32'd4);
    while (hsync !== 1'b0 && cyc < fall1 + 1000) step();
    chk("hsync_period", 32'(cyc - fall1), 32'd535);

    // read_ad across line 5 (sample after edge n shows counters of cycle n-1).
    ks   = '{-1, 0, 7, 8, 255, 256, 534, 535};
    exps = '{159, 160, 160, 161, 191, 191, 191, 192};
    for (int i = 0; i < 8; i++) begin
      run_to(5 * 535 + ks[i] + 1);
      chk("line5_read_ad", 32'(read_ad), 32'(exps[i]));
    end

    // Mid-frame reset at h=100, v=30.
    run_to(30 * 535 + 100);
    chk("pre_reset_de", 32'(de), 32'd1);
    chk("pre_reset_read_ad", 32'(read_ad), 32'd972);
    mem[0]    = 9'h000;
    mem[2047] = 9'h0FF;
    reset_n   = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    while (frame_start !== 1'b1 && cyc < 20) step();
    chk("restart_frame_start_edge", 32'(cyc), 32'd4);
    chk("restart_pixel0", 32'(pixel), 32'd0);

    // Last window word and the first pixels outside the window.
    run_to(62 * 535 + 255 + 4);
    chk("l62_p255", 32'(pixel), 32'd0);
    run_to(63 * 535 + 247 + 4);
    chk("l63_p247", 32'(pixel), 32'd0);
    for (int k = 248; k < 256; k++) begin
      run_to(63 * 535 + k + 4);
      chk("l63_last_word_pixel", 32'(pixel), 32'd1);
      chk("l63_last_word_de", 32'(de), 32'd1);
    end
    run_to(63 * 535 + 256 + 4);
    chk("l63_p256_pixel", 32'(pixel), 32'd0);
    chk("l63_p256_de", 32'(de), 32'd1);
    run_to(64 * 535 + 0 + 4);
    chk("l64_p0_pixel", 32'(pixel), 32'd0);
    chk("l64_p0_de", 32'(de), 32'd1);
    chk("l64_p0_frame_start", 32'(frame_start), 32'd0);
    run_to(64 * 535 + 4 + 4);
    chk("l64_p4_pixel", 32'(pixel), 32'd0);
    run_to(64 * 535 + 10 + 1);
    chk("l64_read_ad_hold", 32'(read_ad), 32'd2047);
    chk("l64_vsync_idle", 32'(vsync), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
